wb_slave_decoder: RTL and testbench
===================================

# wb_slave_decoder

Registered Wishbone slave-side address decoder and response mux for the user project area, generalising the fixed two-target decode (0x30 UART, 0x38 BRAM) to N parametrised targets. It sits between the management SoC Wishbone port and the user slaves. It drives a one-hot `valid` per slave and returns a registered ack/data to the master. Unmapped addresses and hung slaves get a completed cycle with an error pattern, a sticky status and an interrupt pulse, so the bus never stalls.

## Interface
- `N_SLV`, 4: number of slave slots, 1..8.
- `DAT_W`, 32: data width.
- `SLV_BASE`, {8'h32,8'h31,8'h38,8'h30}: packed N_SLV×8 bits; slot i matches when `wbs_adr_i[31:24] == SLV_BASE[8i+:8]`. The lowest matching index wins.
- `TIMEOUT`, 255: maximum BUSY cycles to wait for a slave ack, 1..65535.
- `wb_clk_i`  in  1  clock.
- `wb_rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  master strobes.
- `wbs_sel_i`  in  DAT_W/8  byte select. Passed unregistered to slaves.
- `wbs_adr_i`  in  32  address. Passed unregistered to slaves.
- `wbs_dat_i`  in  DAT_W  write data. Passed unregistered to slaves.
- `wbs_ack_o`  out  1  registered ack to the master.
- `wbs_dat_o`  out  DAT_W  registered read data.
- `slv_valid_o`  out  N_SLV  one-hot slave select. This is the slave's `wb_valid`.
- `slv_ack_i`  in  N_SLV  per-slave ack.
- `slv_dat_i`  in  N_SLV×DAT_W  per-slave read data. Slot i is at `[DAT_W*i +: DAT_W]`.
- `err_irq_o`  out  1  one-cycle pulse on each error.
- `err_sticky_o`  out  2  bit0 = unmapped, bit1 = timeout. Cleared only by reset.
- `err_adr_o`  out  32  address of the most recent error.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - On `cyc&stb`, decode the address and register the slot index.
  - On a hit: go to BUSY and set `slv_valid_o[idx]`.
  - On a miss: go to RESP with data 0xDEAD_BEEF, set `err_sticky_o[0]`, load `err_adr_o`, pulse `err_irq_o`.
- BUSY
  - `slv_valid_o` holds one-hot and the timeout counter increments.
  - Selected `slv_ack_i` sampled high: capture `slv_dat_i[idx]` into `wbs_dat_o`, clear valid, go to RESP.
  - Counter reaches TIMEOUT first: clear valid, output data 0xDEAD_BEEF, set `err_sticky_o[1]`, load `err_adr_o`, pulse irq, go to RESP.
  - A slave ack and the timeout in the same cycle: the ack wins and no error is raised.
- RESP: `wbs_ack_o`=1 for exactly one cycle, then IDLE. The master must have dropped `stb` by the following cycle.
- Abort: `wbs_cyc_i` low while in BUSY clears valid and returns to IDLE with no ack and no error.
- Ignored inputs:
  - Acks from non-selected slots.
  - Any `slv_ack_i` seen in IDLE or RESP.
- Writes follow the same path. `wbs_dat_o` is 0 on a write ack; an error ack on a write still reads back 0xDEAD_BEEF.
- `wbs_dat_o` is 0 whenever `wbs_ack_o` is low.

## Timing
- Reset values (asynchronous on `wb_rst_n_i` low):
  - FSM = IDLE.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `slv_valid_o`=0.
  - `err_irq_o`=0, `err_sticky_o`=0, `err_adr_o`=0, counter=0.
- Reset mid-transaction drops valid immediately. No ack is produced.
- Latency, with the request first seen in IDLE at edge T:
  - Valid asserts after edge T.
  - A slave acking in its first valid cycle makes `wbs_ack_o` high in cycle T+2.
  - A miss acks in T+1.
  - A timeout acks TIMEOUT+2 cycles after T.
- Throughput: back-to-back requests restart in IDLE, giving a minimum of 3 cycles per hit transaction.
- The counter is 16 bits and resets on every BUSY entry. It never wraps because it saturates at TIMEOUT.
- `err_irq_o` rises in the same cycle as the error `wbs_ack_o` (the RESP cycle).

## Structure
- Package `wb_dec_pkg`:
  - State enum IDLE/BUSY/RESP.
  - `ERR_DATA` = 32'hDEAD_BEEF.
  - Error bit indices `ERR_UNMAPPED`=0, `ERR_TIMEOUT`=1.
- Sub-module `wb_dec_timeout`: loadable saturating counter with clear and enable, and an `expired` output. It is instantiated once.
- Decode is a generate loop over `N_SLV` producing a hit vector, followed by a priority encoder to the index.

## Test plan
- Read at 0x3000_0004; slot 0 acks in its first valid cycle with 0x1234_5678 -> `slv_valid_o`=4'b0001 for one cycle; `wbs_ack_o` in T+2 with `wbs_dat_o`=0x1234_5678.
- Write to 0x3800_0000; slot 1 acks after 5 cycles -> valid=4'b0010 for 5 cycles, one ack, `wbs_dat_o`=0.
- Read 0x5000_0000 -> ack in T+1, data 0xDEAD_BEEF, `err_sticky_o`=2'b01, `err_adr_o`=0x5000_0000, one irq pulse, no `slv_valid_o`.
- TIMEOUT=8; slot 2 (0x3100_0000) never acks -> valid for 8 cycles then dropped; ack with 0xDEAD_BEEF; `err_sticky_o[1]`=1.
- Master drops `cyc` in BUSY cycle 3 -> valid clears the next cycle; no ack, no irq. A following read to slot 3 completes normally.
- `wb_rst_n_i` pulsed low during BUSY -> all outputs 0 asynchronously; the first post-reset transaction completes correctly.

Source files
------------

// File: rtl/wb_dec_pkg.sv
// rtl/wb_dec_pkg.sv - shared types and constants for the Wishbone slave decoder
package wb_dec_pkg;

  // Decoder transaction states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Read-back pattern returned on unmapped or timed-out cycles
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Bit positions in err_sticky_o
  localparam int ERR_UNMAPPED = 0;
  localparam int ERR_TIMEOUT  = 1;

  // Width of the slave-ack timeout counter
  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_dec_timeout.sv
// rtl/wb_dec_timeout.sv - loadable saturating counter that flags a hung slave
module wb_dec_timeout #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, stopping at LIMIT so the value never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= CNT_W'(LIMIT));
  // One cycle before expiry, so the owner can drop its request ahead of the error
  assign last    = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_slave_decoder.sv
// rtl/wb_slave_decoder.sv - registered Wishbone address decoder and response mux for N slaves
module wb_slave_decoder
  import wb_dec_pkg::*;
#(
  parameter int                 N_SLV    = 4,
  parameter int                 DAT_W    = 32,
  parameter logic [N_SLV*8-1:0] SLV_BASE = {8'h32, 8'h31, 8'h38, 8'h30},
  parameter int                 TIMEOUT  = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [DAT_W/8-1:0]     wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [DAT_W-1:0]       wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [DAT_W-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]       slv_valid_o,
  input  logic [N_SLV-1:0]       slv_ack_i,
  input  logic [N_SLV*DAT_W-1:0] slv_dat_i,
  output logic                   err_irq_o,
  output logic [1:0]             err_sticky_o,
  output logic [31:0]            err_adr_o
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] hit_idx;
  logic [N_SLV-1:0] hit;
  logic [31:0]      adr_q;
  logic             we_q;
  logic             req;
  logic             sel_ack;
  logic             to_clr;
  logic             to_load;
  logic             to_en;
  logic             to_expired;
  logic             to_last;

  // Byte selects and write data go straight from the master to the slaves
  logic unused_bus;
  assign unused_bus = ^{wbs_sel_i, wbs_dat_i};

  assign req = wbs_cyc_i & wbs_stb_i;

  // Per-slot compare of the top address byte against that slot's base
  for (genvar g = 0; g < N_SLV; g++) begin : g_decode
    assign hit[g] = (wbs_adr_i[31:24] == SLV_BASE[8*g +: 8]);
  end

  // Priority encoder: the lowest matching slot wins
  always_comb begin
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  assign sel_ack = slv_ack_i[idx_q];

  assign to_load = (state == IDLE) && req && (|hit);
  assign to_en   = (state == BUSY);
  assign to_clr  = (state == BUSY) && !wbs_cyc_i;

  wb_dec_timeout #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .clr      (to_clr),
    .load     (to_load),
    .load_val (CNT_W'(0)),
    .en       (to_en),
    .expired  (to_expired),
    .last     (to_last)
  );

  // Transaction FSM with registered ack, data, slave select and error reporting
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state        <= IDLE;
      idx_q        <= '0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      slv_valid_o  <= '0;
      err_irq_o    <= 1'b0;
      err_sticky_o <= '0;
      err_adr_o    <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      err_irq_o <= 1'b0;
      case (state)
        IDLE: begin
          wbs_dat_o <= '0;
          if (req) begin
            adr_q <= wbs_adr_i;
            we_q  <= wbs_we_i;
            if (|hit) begin
              idx_q       <= hit_idx;
              slv_valid_o <= N_SLV'(1) << hit_idx;
              state       <= BUSY;
            end else begin
              wbs_ack_o                  <= 1'b1;
              wbs_dat_o                  <= DAT_W'(ERR_DATA);
              err_sticky_o[ERR_UNMAPPED] <= 1'b1;
              err_adr_o                  <= wbs_adr_i;
              err_irq_o                  <= 1'b1;
              state                      <= RESP;
            end
          end
        end

        BUSY: begin
          if (!wbs_cyc_i) begin
            // Master abandoned the cycle: release the slave silently
            slv_valid_o <= '0;
            state       <= IDLE;
          end else if (sel_ack) begin
            // Checked before expiry so a last-moment ack still completes cleanly
            slv_valid_o <= '0;
            wbs_ack_o   <= 1'b1;
            wbs_dat_o   <= we_q ? '0 : slv_dat_i[DAT_W*idx_q +: DAT_W];
            state       <= RESP;
          end else if (to_expired) begin
            slv_valid_o               <= '0;
            wbs_ack_o                 <= 1'b1;
            wbs_dat_o                 <= DAT_W'(ERR_DATA);
            err_sticky_o[ERR_TIMEOUT] <= 1'b1;
            err_adr_o                 <= adr_q;
            err_irq_o                 <= 1'b1;
            state                     <= RESP;
          end else if (to_last) begin
            // Slave had its TIMEOUT cycles of valid; the error is reported next cycle
            slv_valid_o <= '0;
          end
        end

        RESP: begin
          wbs_dat_o <= '0;
          state     <= IDLE;
        end

        default: begin
          slv_valid_o <= '0;
          wbs_dat_o   <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb/tb_wb_slave_decoder.sv - self-checking bench for wb_slave_decoder
module tb_wb_slave_decoder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [31:0] ERR_PAT = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'h0;
  logic [31:0]   wdat = 32'h0;
  logic          ack;
  logic [31:0]   rdat;
  logic [N-1:0]  valid;
  logic [N-1:0]  slv_ack = '0;
  logic [N*DW-1:0] slv_dat = '0;
  logic          irq;
  logic [1:0]    sticky;
  logic [31:0]   eadr;

  int total = 0;
  int bad   = 0;

  logic [1:0]  exp_sticky = 2'b00;
  logic [31:0] exp_eadr   = 32'h0;
  logic [7:0]  base_tab [N] = '{8'h30, 8'h38, 8'h31, 8'h32};

  wb_slave_decoder #(
    .N_SLV    (N),
    .DAT_W    (DW),
    .SLV_BASE ({8'h32, 8'h31, 8'h38, 8'h30}),
    .TIMEOUT  (TO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .slv_valid_o  (valid),
    .slv_ack_i    (slv_ack),
    .slv_dat_i    (slv_dat),
    .err_irq_o    (irq),
    .err_sticky_o (sticky),
    .err_adr_o    (eadr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_slot(input logic [31:0] a);
    for (int i = 0; i < N; i++) if (a[31:24] == base_tab[i]) return i;
    return -1;
  endfunction

  // One master transaction; the slave acks in its (dly+1)-th valid cycle, never if dly >= TO
  task automatic txn(input string tag, input logic [31:0] a, input logic w,
                     input int dly, input logic [31:0] sd);
    int slot, ack_cyc, vcnt, irqs, acks, irq_at_ack;
    int exp_cyc, exp_v, exp_irq;
    logic [31:0] ack_dat, exp_dat;
    logic [3:0]  vseen, exp_vseen, noise;
    int leak;
    slot = ref_slot(a);
    if (slot < 0) begin
      exp_cyc = 1; exp_dat = ERR_PAT; exp_v = 0; exp_irq = 1; exp_vseen = 4'h0;
      exp_sticky[0] = 1'b1; exp_eadr = a;
    end else if (dly < TO) begin
      exp_cyc = dly + 2; exp_dat = w ? 32'h0 : sd; exp_v = dly + 1; exp_irq = 0;
      exp_vseen = 4'(1 << slot);
    end else begin
      exp_cyc = TO + 2; exp_dat = ERR_PAT; exp_v = TO; exp_irq = 1;
      exp_vseen = 4'(1 << slot);
      exp_sticky[1] = 1'b1; exp_eadr = a;
    end

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = $urandom; sel = 4'hF; slv_ack = '0;
    for (int i = 0; i < N; i++) slv_dat[DW*i +: DW] = $urandom;
    if (slot >= 0) slv_dat[DW*slot +: DW] = sd;
    ack_cyc = -1; vcnt = 0; vseen = 4'h0; irqs = 0; acks = 0; irq_at_ack = 0;
    leak = 0; ack_dat = 32'h0;
    for (int c = 1; c <= TO + 12; c++) begin
      @(negedge clk);
      if (valid != '0) begin vcnt++; vseen |= valid; end
      if (irq) irqs++;
      if (ack) begin
        acks++;
        if (ack_cyc < 0) begin ack_cyc = c; ack_dat = rdat; irq_at_ack = int'(irq); end
        cyc = 1'b0; stb = 1'b0;
      end else if (rdat != 32'h0) begin
        leak = 1;
      end
      noise = 4'($urandom) & ~((slot >= 0) ? 4'(1 << slot) : 4'h0);
      if (valid != '0 && vcnt == dly + 1) slv_ack = valid;
      else slv_ack = noise & ~valid;
      if (ack_cyc > 0 && c >= ack_cyc + 2) break;
    end
    cyc = 1'b0; stb = 1'b0; slv_ack = '0;

    chk({tag, "_ack_cycle"}, ack_cyc, exp_cyc);
    chk({tag, "_ack_data"}, ack_dat, exp_dat);
    chk({tag, "_ack_count"}, acks, 1);
    chk({tag, "_valid_cycles"}, vcnt, exp_v);
    chk({tag, "_valid_onehot"}, {28'h0, vseen}, {28'h0, exp_vseen});
    chk({tag, "_irq_count"}, irqs, exp_irq);
    chk({tag, "_irq_with_ack"}, irq_at_ack, exp_irq);
    chk({tag, "_dat_idle_zero"}, leak, 0);
    chk({tag, "_sticky"}, {30'h0, sticky}, {30'h0, exp_sticky});
    chk({tag, "_err_adr"}, eadr, exp_eadr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {31'h0, ack}, 32'h0);
    chk({tag, "_dat"}, rdat, 32'h0);
    chk({tag, "_valid"}, {28'h0, valid}, 32'h0);
    chk({tag, "_irq"}, {31'h0, irq}, 32'h0);
    chk({tag, "_sticky"}, {30'h0, sticky}, 32'h0);
    chk({tag, "_err_adr"}, eadr, 32'h0);
  endtask

  initial begin
    int vcnt, acks, irqs, slot_r, dly;
    logic [31:0] a;

    // Reset held low
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed scenarios
    txn("rd_slot0", 32'h3000_0004, 1'b0, 0, 32'h1234_5678);
    txn("wr_slot1", 32'h3800_0000, 1'b1, 4, 32'hA5A5_0001);
    txn("rd_miss", 32'h5000_0000, 1'b0, 0, 32'h0);
    txn("rd_timeout", 32'h3100_0000, 1'b0, 99, 32'h0);
    txn("ack_at_limit", 32'h3200_0008, 1'b0, TO - 1, 32'h0BAD_F00D);
    txn("wr_timeout", 32'h3100_0040, 1'b1, 99, 32'h0);
    txn("wr_miss", 32'h0000_1000, 1'b1, 0, 32'h0);

    // Abort in the third BUSY cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3200_0010; slv_ack = '0;
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (valid != '0) vcnt++;
      if (vcnt == 3) break;
    end
    chk("abort_reached_busy3", vcnt, 3);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_valid_clear", {28'h0, valid}, 32'h0);
    acks = 0; irqs = 0;
    for (int c = 0; c < TO + 4; c++) begin
      if (ack) acks++;
      if (irq) irqs++;
      @(negedge clk);
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_no_irq", irqs, 0);
    chk("abort_sticky", {30'h0, sticky}, {30'h0, exp_sticky});
    txn("after_abort", 32'h3200_0020, 1'b0, 2, 32'h5555_AAAA);

    // Reset pulsed in the middle of BUSY
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; slv_ack = '0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_valid", {28'h0, valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    exp_sticky = 2'b00; exp_eadr = 32'h0;
    chk_all_zero("midrst_async");
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn("post_reset", 32'h3800_0100, 1'b0, 1, 32'hCAFE_0001);

    // Randomized traffic against the reference rules
    for (int k = 0; k < 40; k++) begin
      slot_r = $urandom_range(0, 5);
      a = $urandom;
      if (slot_r < N) a[31:24] = base_tab[slot_r];
      if ($urandom_range(0, 5) == 0) dly = 99;
      else dly = $urandom_range(0, TO - 1);
      txn($sformatf("rnd%0d", k), a, 1'($urandom), dly, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
